instruction_cache: RTL

INSTRUCTION_CACHE -- requirements
Module: instruction_cache

---
 rtl/ap_pkg.sv | 15 +
 rtl/ins_cache_ram.sv | 36 +++
 rtl/instruction_cache.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ap_pkg.sv
// Shared AP state encodings and widths used by the instruction cache and program_counter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ap_pkg;

    localparam int LOAD_TIMES_W = 10;

    // Fetch-side FSM states; encodings are visible on st_cur_ins_cache.
    typedef enum logic [3:0] {
        START    = 4'd1,
        LOAD_INS = 4'd2,
        SENT_INS = 4'd3
    } ins_cache_st_t;

endpackage

// File: rtl/ins_cache_ram.sv
// Single-block instruction storage: DEPTH x WIDTH, synchronous write, registered read.
// Latency: read data appears one cycle after rd_en; it holds its value while rd_en is low.
// Backpressure: none; write and read ports are always ready.
module ins_cache_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Array write; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register; only updates on a read so the last word stays visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/instruction_cache.sv
// One-block instruction cache: fills ISA_DEPTH words on a miss, serves hits from local RAM.
// Latency: hit -> ins_valid 1 cycle after START; miss -> 2 cycles per word fill then START.
// Backpressure: one outstanding memory read, held until mem_rd_valid. ICACHE_PERF_CNT_EN adds hit/miss counters.
module instruction_cache
    import ap_pkg::*;
#(
    parameter int ADDR_WIDTH_MEM = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int ISA_DEPTH      = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH_MEM-1:0] addr_ins,
    output logic                      ins_cache_rdy,
    output logic [3:0]                st_cur_ins_cache,
    output logic [LOAD_TIMES_W-1:0]   load_times,
    output logic [DATA_WIDTH-1:0]     ins_out,
    output logic                      ins_valid,
    output logic                      mem_rd_req,
    output logic [ADDR_WIDTH_MEM-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]     mem_rd_data,
    input  logic                      mem_rd_valid
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [15:0]               hit_cnt,
    output logic [15:0]               miss_cnt
`endif
);

    localparam int OFF_W = $clog2(ISA_DEPTH);
    localparam int BLK_W = ADDR_WIDTH_MEM - OFF_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(ISA_DEPTH - 1);

    ins_cache_st_t    st;
    logic [BLK_W-1:0] cur_blk;
    logic [OFF_W-1:0] word_cnt;
    logic             resident;
    logic [BLK_W-1:0] blk;
    logic             hit;
    logic             ram_wr_en;
    logic             ram_rd_en;

    assign blk              = addr_ins[ADDR_WIDTH_MEM-1:OFF_W];
    assign hit              = resident && (blk == cur_blk);
    assign st_cur_ins_cache = st;

    // A fill word is taken only while a request is actually outstanding.
    assign ram_wr_en = (st == LOAD_INS) && mem_rd_req && mem_rd_valid;
    assign ram_rd_en = (st == START) && hit;

    ins_cache_ram #(
        .DEPTH (ISA_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ram_wr_en),
        .wr_addr (word_cnt),
        .wr_data (mem_rd_data),
        .rd_en   (ram_rd_en),
        .rd_addr (addr_ins[OFF_W-1:0]),
        .rd_data (ins_out)
    );

    // Fetch FSM: serve hits, refill the single block on a miss, one read in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st            <= LOAD_INS;
            cur_blk       <= '0;
            word_cnt      <= '0;
            resident      <= 1'b0;
            load_times    <= '0;
            ins_cache_rdy <= 1'b0;
            ins_valid     <= 1'b0;
            mem_rd_req    <= 1'b0;
            mem_addr      <= '0;
        end else begin
            ins_valid <= 1'b0;
            case (st)
                START: begin
                    if (hit) begin
                        st        <= SENT_INS;
                        ins_valid <= 1'b1;
                    end else begin
                        cur_blk       <= blk;
                        resident      <= 1'b0;
                        word_cnt      <= '0;
                        ins_cache_rdy <= 1'b0;
                        st            <= LOAD_INS;
                    end
                end
                LOAD_INS: begin
                    if (!mem_rd_req) begin
                        mem_rd_req <= 1'b1;
                        mem_addr   <= {cur_blk, word_cnt};
                    end else if (mem_rd_valid) begin
                        mem_rd_req <= 1'b0;
                        word_cnt   <= word_cnt + 1'b1;
                        if (word_cnt == LAST_WORD) begin
                            resident      <= 1'b1;
                            // Top block wraps to 0 through the 10-bit truncation.
                            load_times    <= LOAD_TIMES_W'(cur_blk) + LOAD_TIMES_W'(1);
                            ins_cache_rdy <= 1'b1;
                            st            <= START;
                        end
                    end
                end
                SENT_INS: begin
                    st <= START;
                end
                default: begin
                    st <= LOAD_INS;
                end
            endcase
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    // Saturating hit/miss counters sampled on the START decision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (st == START) begin
            if (hit) begin
                if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            end else begin
                if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
